// File: rtl/fft_frame_seq_if.sv
// Upstream sample handshake into the FFT frame sequencer.
// The source drives in_valid; the sequencer answers with in_ready.
interface fft_frame_seq_if;
  logic in_valid;
  logic in_ready;

  modport master (
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/fft_frame_seq.sv
// Frame sequencer for the 32-point radix-2 SDF FFT: frames input samples, zero-pads stalls,
// and tags pipeline outputs with bin index / last / frame count. Macro FFT_SEQ_BITREV_EN selects bit-reversed bin tags.
module fft_frame_seq #(
  parameter int N        = 32,
  parameter int LOG2N    = 5,
  parameter int PIPE_LAT = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  fft_frame_seq_if.slave   in_if,
  input  logic             flush_i,
  input  logic             err_clr_i,
  output logic             pipe_valid_o,
  output logic             pad_o,
  output logic [LOG2N-1:0] in_idx_o,
  output logic             out_valid_o,
  output logic [LOG2N-1:0] out_idx_o,
  output logic             out_last_o,
  output logic [7:0]       frames_o,
  output logic             err_gap_o,
  output logic             busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  state_t             r_state;
  logic [LOG2N-1:0]   r_cnt;
  logic [LOG2N-1:0]   r_in_idx;
  logic [LOG2N-1:0]   r_ocnt;
  logic               r_pipe_valid;
  logic               r_pad;
  logic               r_err_gap;
  logic [7:0]         r_frames;
  logic [PIPE_LAT-1:0] r_sr;

  logic [PIPE_LAT-1:0] w_sr_next;
  logic [LOG2N-1:0]    w_ocnt_rev;
  logic                w_accept;
  logic                w_gap;
  logic                w_out_valid;
  logic                w_out_last;

  assign in_if.in_ready = !flush_i;
  assign w_accept       = in_if.in_valid && !flush_i;
  // A missing sample while loading becomes a pad slot; flush abandons the frame instead.
  assign w_gap          = (r_state == LOAD) && !in_if.in_valid && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_pipe_valid <= 1'b0;
      r_pad        <= 1'b0;
      r_in_idx     <= '0;
      r_err_gap    <= 1'b0;
    end else begin
      if (flush_i) begin
        r_state      <= IDLE;
        r_cnt        <= '0;
        r_pipe_valid <= 1'b0;
        r_pad        <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_pipe_valid <= 1'b1;
              r_pad        <= 1'b0;
              r_in_idx     <= '0;
              r_cnt        <= LOG2N'(1);
              r_state      <= LOAD;
            end else begin
              r_pipe_valid <= 1'b0;
              r_pad        <= 1'b0;
            end
          end
          LOAD: begin
            // A started frame always runs N slots; stalls are filled with pads.
            r_pipe_valid <= 1'b1;
            r_in_idx     <= r_cnt;
            r_pad        <= !in_if.in_valid;
            if (r_cnt == LAST_IDX) begin
              r_cnt   <= '0;
              r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt + LOG2N'(1);
            end
          end
          default: begin
            r_state      <= IDLE;
            r_pipe_valid <= 1'b0;
            r_pad        <= 1'b0;
          end
        endcase
      end
      // A new gap beats a simultaneous clear so no padded frame goes unreported.
      if (w_gap) begin
        r_err_gap <= 1'b1;
      end else if (err_clr_i) begin
        r_err_gap <= 1'b0;
      end
    end
  end

  // Latency line: bit gi holds pipe_valid delayed by gi+1 cycles.
  genvar gi;
  generate
    for (gi = 0; gi < PIPE_LAT; gi++) begin : g_lat
      if (gi == 0) begin : g_head
        assign w_sr_next[gi] = r_pipe_valid;
      end else begin : g_tail
        assign w_sr_next[gi] = r_sr[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else if (flush_i) begin
      r_sr <= '0;
    end else begin
      r_sr <= w_sr_next;
    end
  end

  assign w_out_valid = r_sr[PIPE_LAT-1];
  assign w_out_last  = w_out_valid && (r_ocnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ocnt   <= '0;
      r_frames <= '0;
    end else begin
      if (flush_i) begin
        r_ocnt <= '0;
      end else if (w_out_valid) begin
        r_ocnt <= r_ocnt + LOG2N'(1);
      end
      // Completed frames are counted even across a flush; the counter wraps naturally.
      if (w_out_last) begin
        r_frames <= r_frames + 8'd1;
      end
    end
  end

  generate
    for (gi = 0; gi < LOG2N; gi++) begin : g_rev
      assign w_ocnt_rev[gi] = r_ocnt[LOG2N-1-gi];
    end
  endgenerate

`ifdef FFT_SEQ_BITREV_EN
  assign out_idx_o = w_ocnt_rev;
`else
  assign out_idx_o = r_ocnt;
`endif

  assign pipe_valid_o = r_pipe_valid;
  assign pad_o        = r_pad;
  assign in_idx_o     = r_in_idx;
  assign out_valid_o  = w_out_valid;
  assign out_last_o   = w_out_last;
  assign frames_o     = r_frames;
  assign err_gap_o    = r_err_gap;
  assign busy_o       = (r_state == LOAD) || r_pipe_valid || (|r_sr);

`ifndef FFT_SEQ_BITREV_EN
  logic w_unused_rev;
  assign w_unused_rev = ^w_ocnt_rev;
`endif

endmodule

// File: doc/fft_frame_seq.md
# fft_frame_seq

Frame-level sequencer at the head of the 32-point radix-2 SDF FFT pipeline. It accepts input samples over a valid/ready handshake, groups them into 32-sample frames, and drives the first stage controller's valid strobe. If the source stalls mid-frame, it zero-pads and flags the gap. It also tracks pipeline latency so that every output sample is tagged with its frequency-bin index, last-of-frame and frame count.

## Interface
- N, 32: points per frame, power of two.
- LOG2N, 5: log2(N); width of index buses.
- PIPE_LAT, 31: cycles from pipe_valid_o high to the corresponding FFT result at the last stage output; legal range 1..64.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream sample present.
- in_ready  out  1  sequencer accepts a sample this cycle; combinational, equal to !flush_i.
- flush_i  in  1  synchronous abort of all frames in flight.
- err_clr_i  in  1  clears err_gap_o.
- pipe_valid_o  out  1  registered; drives valid_i of the first stage controller and the datapath input register enable.
- pad_o  out  1  registered; the datapath forces the stage-1 input to 0+j0 while high.
- in_idx_o  out  LOG2N  registered sample index (0..N-1) of the current pipe_valid_o cycle.
- out_valid_o  out  1  last-stage output is a valid bin.
- out_idx_o  out  LOG2N  bin index of the current output.
- out_last_o  out  1  high with the final output sample of a frame.
- frames_o  out  8  completed output frames, wraps 255→0.
- err_gap_o  out  1  sticky: a frame was zero-padded.
- busy_o  out  1  a frame is loading or in flight.

## Operation
- FSM with 2 states: IDLE, LOAD. Input counter cnt[LOG2N-1:0].
- Acceptance: a sample is accepted in a cycle when in_valid && in_ready.
- IDLE, sample accepted:
  - Register pipe_valid_o=1, pad_o=0, in_idx_o=0.
  - cnt←1, go to LOAD.
  - Otherwise pipe_valid_o←0.
- LOAD, every cycle:
  - Register pipe_valid_o=1 and in_idx_o=cnt.
  - If in_valid=0, register pad_o=1 and set err_gap_o.
  - cnt←cnt+1.
  - When cnt==N-1, go to IDLE with cnt←0.
  - A frame always occupies exactly N consecutive pipe_valid_o cycles.
- Back-to-back frames: in_valid high in the IDLE cycle after sample N-1 starts the next frame. pipe_valid_o stays continuously high with no bubble.
- Output tracking:
  - A PIPE_LAT-deep shift register delays pipe_valid_o; out_valid_o is its tail.
  - An output counter ocnt[LOG2N-1:0] increments on each out_valid_o and wraps N-1→0.
  - out_last_o = out_valid_o && ocnt==N-1.
  - frames_o increments on the cycle after out_last_o.
- out_idx_o = bitrev(ocnt) when the bit-reversal macro is enabled; see Configuration.
- busy_o = (state==LOAD) || pipe_valid_o || any shift-register bit || out_valid_o.
- flush_i, next cycle:
  - State IDLE, cnt=0, ocnt=0.
  - pipe_valid_o=0, pad_o=0, shift register all zero.
  - Samples offered during the flush cycle are not accepted.
  - err_gap_o and frames_o are retained.
- err_gap_o: if err_clr_i and a new gap occur in the same cycle, set wins.
- Reset:
  - All outputs 0, except in_ready, which follows !flush_i.
  - State IDLE; all counters and the shift register 0.

## Timing
- Sample accepted in cycle k → pipe_valid_o/in_idx_o/pad_o valid in cycle k+1.
- pipe_valid_o high in cycle m → out_valid_o high in cycle m+PIPE_LAT.
- out_last_o in cycle p → frames_o updated in cycle p+1.
- err_gap_o rises in the same cycle as the pad_o=1 it records.
- flush_i in cycle f → pipe_valid_o=0 and out_valid_o=0 from cycle f+1; busy_o=0 from f+1 unless a new sample is accepted in f+1.
- Reset asserted mid-frame takes effect immediately (asynchronous); after release the block is in IDLE with no output tags.

## Configuration
- FFT_SEQ_BITREV_EN defined: out_idx_o = bit-reversed ocnt. This is the natural bin index for the DIF SDF output order.
- Not defined: out_idx_o = ocnt. This is for builds with a reorder buffer downstream, which tags sequential position only.

## Test plan
All scenarios use N=32 and PIPE_LAT=8.
- Reset check: assert rst_n=0 mid-LOAD → every output 0 in the same cycle; after release, in_ready=1 and busy_o=0.
- Single frame: in_valid high cycles 0..31 →
  - pipe_valid_o cycles 1..32, in_idx_o 0..31.
  - out_valid_o cycles 9..40, out_idx_o 0,16,8,24,4,… (BITREV_EN).
  - out_last_o cycle 40, frames_o=1 at cycle 41.
- Back-to-back: in_valid high cycles 0..63 →
  - pipe_valid_o continuous 1..64, in_idx_o wraps 31→0 at cycle 33.
  - out_last_o cycles 40 and 72, frames_o=2.
- Gap: in_valid low only at cycle 10 →
  - pad_o=1 and in_idx_o=10 at cycle 11, err_gap_o=1 from cycle 11.
  - Frame still 32 samples.
  - err_clr_i cycle 50 clears err_gap_o; err_clr_i coincident with a new gap leaves it 1.
- Flush: flush_i at cycle 20 of a frame → in_ready=0 in cycle 20; pipe_valid_o=0, out_valid_o=0 and busy_o=0 from cycle 21; frames_o unchanged.
- Macro off: single frame → out_idx_o 0,1,2,…,31.
